// File: rtl/fwrisc_prog_loader_pkg.sv
// Shared definitions for the framed program loader: state codes, sync byte, error codes.
// The optional trailing checksum is enabled by defining PROG_LOADER_CHKSUM_EN.
package fwrisc_prog_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_SYNC  = 3'd0;
  localparam state_t ST_LEN_H = 3'd1;
  localparam state_t ST_LEN_L = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_CSUM  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
  localparam state_t ST_ERR   = 3'd6;

  localparam logic [7:0] SYNC_BYTE = 8'h5A;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_CSUM    = 2'b11;

  // A frame must carry at least one word and must fit in the ITCM.
  function automatic logic len_ok(input logic [15:0] len, input int unsigned aw);
    return (len != 16'd0) && ({16'd0, len} <= (32'd1 << aw));
  endfunction

endpackage

// File: rtl/fwrisc_prog_word_pack.sv
// Packs payload bytes MSB-first into 32-bit words; word_valid pulses the cycle
// after the fourth byte of each word, while word holds the completed word.
module fwrisc_prog_word_pack (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] byte_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_cnt   <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && (byte_cnt == 2'd3);
      if (byte_valid) begin
        word     <= {word[23:0], byte_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/fwrisc_prog_loader.sv
// Framed UART-to-ITCM program loader that holds the core in reset until a valid image lands.
// Define PROG_LOADER_CHKSUM_EN to require a trailing 8-bit payload checksum byte.
module fwrisc_prog_loader
  import fwrisc_prog_loader_pkg::*;
#(
  parameter int ITCM_AW     = 12,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  output logic               rx_en_o,
  output logic               itcm_we_o,
  output logic [ITCM_AW-1:0] itcm_addr_o,
  output logic [31:0]        itcm_wdata_o,
  output logic               core_reset_o,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         err_code_o
);

  localparam int           TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t             state;
  logic [7:0]         len_hi;
  logic [15:0]        len;
  logic [ITCM_AW-1:0] addr;
  logic [TW-1:0]      to_cnt;
  logic [1:0]         err_code;

  logic        in_data;
  logic        frame_active;
  logic        sync_hit;
  logic        last_write;
  logic        pack_valid;
  logic        timeout_hit;
  logic        word_valid;
  logic [31:0] word;

  assign in_data      = (state == ST_DATA);
  assign frame_active = state inside {ST_LEN_H, ST_LEN_L, ST_DATA, ST_CSUM};
  assign sync_hit     = (state == ST_SYNC) && rx_valid_i && (rx_data_i == SYNC_BYTE);
  assign last_write   = in_data && word_valid && ({20'd0, addr} == ({16'd0, len} - 32'd1));
  // A byte arriving in the cycle of the final write is past the payload.
  assign pack_valid   = in_data && rx_valid_i && !last_write;
  assign timeout_hit  = frame_active && !rx_valid_i && (to_cnt == TO_LAST);

  fwrisc_prog_word_pack u_pack (
    .clock      (clock),
    .reset      (reset),
    .clear      (sync_hit),
    .byte_valid (pack_valid),
    .byte_data  (rx_data_i),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clock) begin
    if (reset || rx_valid_i || !frame_active) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LAST) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clock) begin
    if (reset || sync_hit) begin
      csum <= 8'd0;
    end else if (pack_valid) begin
      csum <= csum + rx_data_i;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_SYNC;
      err_code <= ERR_NONE;
      len_hi   <= 8'd0;
      len      <= 16'd0;
      addr     <= '0;
    end else if (timeout_hit) begin
      state    <= ST_ERR;
      err_code <= ERR_TIMEOUT;
    end else begin
      case (state)
        ST_SYNC: begin
          if (sync_hit) begin
            state <= ST_LEN_H;
            addr  <= '0;
          end
        end
        ST_LEN_H: begin
          if (rx_valid_i) begin
            len_hi <= rx_data_i;
            state  <= ST_LEN_L;
          end
        end
        ST_LEN_L: begin
          if (rx_valid_i) begin
            len <= {len_hi, rx_data_i};
            if (len_ok({len_hi, rx_data_i}, ITCM_AW)) begin
              state <= ST_DATA;
            end else begin
              state    <= ST_ERR;
              err_code <= ERR_LEN;
            end
          end
        end
        ST_DATA: begin
          if (word_valid) begin
            if (last_write) begin
`ifdef PROG_LOADER_CHKSUM_EN
              if (rx_valid_i) begin
                if (rx_data_i == csum) begin
                  state <= ST_DONE;
                end else begin
                  state    <= ST_ERR;
                  err_code <= ERR_CSUM;
                end
              end else begin
                state <= ST_CSUM;
              end
`else
              state <= ST_DONE;
`endif
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
`ifdef PROG_LOADER_CHKSUM_EN
        ST_CSUM: begin
          if (rx_valid_i) begin
            if (rx_data_i == csum) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_ERR;
              err_code <= ERR_CSUM;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign rx_en_o      = !((state == ST_DONE) || (state == ST_ERR));
  assign core_reset_o = (state != ST_DONE);
  assign done_o       = (state == ST_DONE);
  assign err_o        = (state == ST_ERR);
  assign err_code_o   = err_code;
  assign itcm_we_o    = word_valid && in_data;
  assign itcm_addr_o  = addr;
  assign itcm_wdata_o = word;

endmodule

// File: tb/tb_fwrisc_prog_loader.sv
// Directed self-checking bench for fwrisc_prog_loader; checksum steps run only
// when PROG_LOADER_CHKSUM_EN is defined.
module tb_fwrisc_prog_loader;

  localparam int ITCM_AW     = 12;
  localparam int TIMEOUT_CYC = 40;
  localparam int LOG_DEPTH   = 8192;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [7:0]         rx_data_i = 8'd0;
  logic               rx_valid_i = 1'b0;
  logic               rx_en_o;
  logic               itcm_we_o;
  logic [ITCM_AW-1:0] itcm_addr_o;
  logic [31:0]        itcm_wdata_o;
  logic               core_reset_o;
  logic               done_o;
  logic               err_o;
  logic [1:0]         err_code_o;

  fwrisc_prog_loader #(
    .ITCM_AW     (ITCM_AW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_en_o      (rx_en_o),
    .itcm_we_o    (itcm_we_o),
    .itcm_addr_o  (itcm_addr_o),
    .itcm_wdata_o (itcm_wdata_o),
    .core_reset_o (core_reset_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  always #5 clock = ~clock;

  int         compared   = 0;
  int         mismatched = 0;
  int         wr_cnt     = 0;
  logic [31:0] wr_addr [0:LOG_DEPTH-1];
  logic [31:0] wr_data [0:LOG_DEPTH-1];
  logic [7:0]  csum;
  int          base;

  // ITCM write log, sampled on the falling edge.
  always @(negedge clock) begin
    if (itcm_we_o === 1'b1) begin
      if (wr_cnt < LOG_DEPTH) begin
        wr_addr[wr_cnt] = 32'(itcm_addr_o);
        wr_data[wr_cnt] = itcm_wdata_o;
      end
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    rx_valid_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    csum  = 8'd0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clock);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_pl(input logic [7:0] b);
    send(b);
    csum = csum + b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic end_frame();
`ifdef PROG_LOADER_CHKSUM_EN
    send(csum);
`endif
  endtask

  task automatic check_write(input string tag, input int idx,
                             input logic [31:0] addr, input logic [31:0] data);
    if (idx < wr_cnt && idx < LOG_DEPTH) begin
      check({tag, "_addr"}, wr_addr[idx], addr);
      check({tag, "_data"}, wr_data[idx], data);
    end else begin
      check({tag, "_present"}, 32'(wr_cnt), 32'(idx + 1));
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_rx_en",      32'(rx_en_o),      32'd1);
    check("rst_core_reset", 32'(core_reset_o), 32'd1);
    check("rst_done",       32'(done_o),       32'd0);
    check("rst_err",        32'(err_o),        32'd0);
    check("rst_err_code",   32'(err_code_o),   32'd0);
    check("rst_we",         32'(itcm_we_o),    32'd0);
    check("rst_addr",       32'(itcm_addr_o),  32'd0);
    check("rst_wdata",      itcm_wdata_o,      32'd0);

    // Two-word frame
    base = wr_cnt;
    send(8'h5A); send(8'h00); send(8'h02);
    send_pl(8'h12); send_pl(8'h34); send_pl(8'h56); send_pl(8'h78);
    send_pl(8'h9A); send_pl(8'hBC); send_pl(8'hDE); send_pl(8'hF0);
    check("t1_we_last",     32'(itcm_we_o), 32'd1);
    check("t1_done_early",  32'(done_o),    32'd0);
    end_frame();
    idle(2);
    check("t1_count",      32'(wr_cnt - base), 32'd2);
    check_write("t1_w0", base,     32'd0, 32'h12345678);
    check_write("t1_w1", base + 1, 32'd1, 32'h9ABCDEF0);
    check("t1_done",       32'(done_o),       32'd1);
    check("t1_core_reset", 32'(core_reset_o), 32'd0);
    check("t1_rx_en",      32'(rx_en_o),      32'd0);
    check("t1_err",        32'(err_o),        32'd0);

    // Junk before sync is dropped
    do_reset();
    base = wr_cnt;
    send(8'h00); send(8'hFF); send(8'h33);
    send(8'h5A); send(8'h00); send(8'h01);
    send_pl(8'hDE); send_pl(8'hAD); send_pl(8'hBE); send_pl(8'hEF);
    end_frame();
    idle(2);
    check("t2_count", 32'(wr_cnt - base), 32'd1);
    check_write("t2_w0", base, 32'd0, 32'hDEADBEEF);
    check("t2_done",  32'(done_o), 32'd1);

    // Zero length
    do_reset();
    base = wr_cnt;
    send(8'h5A); send(8'h00); send(8'h00);
    idle(2);
    check("t3a_err",        32'(err_o),          32'd1);
    check("t3a_err_code",   32'(err_code_o),     32'd1);
    check("t3a_count",      32'(wr_cnt - base),  32'd0);
    check("t3a_core_reset", 32'(core_reset_o),   32'd1);
    check("t3a_rx_en",      32'(rx_en_o),        32'd0);
    check("t3a_done",       32'(done_o),         32'd0);

    // One word beyond capacity
    do_reset();
    base = wr_cnt;
    send(8'h5A); send(8'h10); send(8'h01);
    idle(2);
    check("t3b_err",      32'(err_o),         32'd1);
    check("t3b_err_code", 32'(err_code_o),    32'd1);
    check("t3b_count",    32'(wr_cnt - base), 32'd0);

    // Exactly full ITCM: last write lands on the top word and the address holds
    do_reset();
    base = wr_cnt;
    send(8'h5A); send(8'h10); send(8'h00);
    for (int w = 0; w < 4096; w++) begin
      for (int b = 0; b < 4; b++) begin
        send_pl(8'((4 * w + b) & 255));
      end
    end
    end_frame();
    idle(2);
    check("t3c_count", 32'(wr_cnt - base), 32'd4096);
    check_write("t3c_first", base,        32'd0,    32'h00010203);
    check_write("t3c_last",  base + 4095, 32'd4095, 32'hFCFDFEFF);
    check("t3c_addr_hold", 32'(itcm_addr_o), 32'd4095);
    check("t3c_done",      32'(done_o),      32'd1);
    check("t3c_err",       32'(err_o),       32'd0);
    send(8'h5A); send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(2);
    check("t3c_post_ignored", 32'(wr_cnt - base), 32'd4096);
    check("t3c_post_done",    32'(done_o),        32'd1);

    // Inter-byte timeout inside the payload
    do_reset();
    base = wr_cnt;
    send(8'h5A); send(8'h00); send(8'h01); send_pl(8'hAA);
    idle(35);
    check("t4_err_early", 32'(err_o), 32'd0);
    idle(10);
    check("t4_err",        32'(err_o),         32'd1);
    check("t4_err_code",   32'(err_code_o),    32'd2);
    check("t4_count",      32'(wr_cnt - base), 32'd0);
    check("t4_core_reset", 32'(core_reset_o),  32'd1);
    check("t4_done",       32'(done_o),        32'd0);

    // A byte in the expiry cycle wins and restarts the count
    do_reset();
    base = wr_cnt;
    send(8'h5A);
    idle(TIMEOUT_CYC - 1);
    send(8'h00);
    check("t4b_err_tie", 32'(err_o), 32'd0);
    idle(TIMEOUT_CYC - 1);
    send(8'h01);
    send_pl(8'h01); send_pl(8'h23); send_pl(8'h45); send_pl(8'h67);
    end_frame();
    idle(2);
    check("t4b_done",  32'(done_o),        32'd1);
    check("t4b_err",   32'(err_o),         32'd0);
    check("t4b_count", 32'(wr_cnt - base), 32'd1);
    check_write("t4b_w0", base, 32'd0, 32'h01234567);

`ifdef PROG_LOADER_CHKSUM_EN
    // Checksum accepted after a pause, and rejected when wrong
    do_reset();
    base = wr_cnt;
    send(8'h5A); send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(2);
    check("t5a_done_wait", 32'(done_o), 32'd0);
    send(8'h0A);
    check("t5a_done_next", 32'(done_o), 32'd1);
    idle(2);
    check("t5a_err",   32'(err_o),         32'd0);
    check("t5a_count", 32'(wr_cnt - base), 32'd1);

    do_reset();
    send(8'h5A); send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h0B);
    idle(2);
    check("t5b_err",      32'(err_o),      32'd1);
    check("t5b_err_code", 32'(err_code_o), 32'd3);
    check("t5b_done",     32'(done_o),     32'd0);
`endif

    // Reset mid-frame discards the partial word
    do_reset();
    base = wr_cnt;
    send(8'h5A); send(8'h00); send(8'h01); send_pl(8'h11); send_pl(8'h22);
    do_reset();
    send(8'h5A); send(8'h00); send(8'h01);
    send_pl(8'hA1); send_pl(8'hB2); send_pl(8'hC3); send_pl(8'hD4);
    end_frame();
    idle(2);
    check("t6_count", 32'(wr_cnt - base), 32'd1);
    check_write("t6_w0", base, 32'd0, 32'hA1B2C3D4);
    check("t6_done",  32'(done_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
